frodo_mac4: RTL and testbench

- Four-lane multiply-accumulate datapath directly downstream of the matrix address generator.
- Consumes the scalar operand mac_A, the packed 4x16-bit row operand mac_B and the packed 4x16-bit addend mac_C.
- Returns four 16-bit results reduced mod q, which the generator writes back as mac_data_0..3.
- Supports internal accumulation across consecutive k-loop beats, so a running sum is not re-read from RAM every beat.

---
 rtl/frodo_pkg.sv | 24 ++
 rtl/frodo_mac_lane.sv | 51 +++++
 rtl/frodo_mac4.sv | 94 +++++++++
 tb/tb_frodo_mac4.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frodo_pkg.sv
// Shared definitions for the FrodoKEM four-lane MAC datapath:
// lane geometry, parameter-set encodings and the per-mode modulus mask.
package frodo_pkg;

    localparam int LANES = 4;
    localparam int W     = 16;

    typedef enum logic [1:0] {
        MODE_640  = 2'd0,
        MODE_976  = 2'd1,
        MODE_1344 = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // q is a power of two, so reduction mod q is a bit mask; the reserved
    // encoding falls back to the 2^16 modulus.
    function automatic logic [W-1:0] q_mask(input logic [1:0] mode);
        if (mode_e'(mode) == MODE_640) begin
            return 16'h7FFF;
        end
        return 16'hFFFF;
    endfunction

endpackage

// File: rtl/frodo_mac_lane.sv
// One 16-bit MAC lane: low half of the product in stage 1, then
// addend select, modulus mask and the running-sum register in stage 2.
module frodo_mac_lane
    import frodo_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         s1_load_i,
    input  logic         s2_load_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic         first_i,
    input  logic [W-1:0] mask_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] p_d;
    logic [W-1:0] p_q;
    logic [W-1:0] c_q;
    logic [W-1:0] addend;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Only the low W bits of the product matter since q divides 2^W.
    assign p_d    = a_i * b_i;
    assign addend = first_i ? c_q : data_q;
    assign data_d = (p_q + addend) & mask_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            c_q <= '0;
        end else if (s1_load_i) begin
            p_q <= p_d;
            c_q <= c_i;
        end
    end

    // Holds across bubbles and stalls so a sum can resume on the next beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (s2_load_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/frodo_mac4.sv
// Four-lane multiply-accumulate stage behind the matrix address generator:
// two-stage pipeline with valid/ready flow control and in-lane accumulation.
module frodo_mac4
    import frodo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [W-1:0]       mac_A,
    input  logic [LANES*W-1:0] mac_B,
    input  logic [LANES*W-1:0] mac_C,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [W-1:0]       mac_data_0,
    output logic [W-1:0]       mac_data_1,
    output logic [W-1:0]       mac_data_2,
    output logic [W-1:0]       mac_data_3
);

    logic         adv;
    logic         accept;
    logic         s2_load;
    logic [W-1:0] mask;

    logic         v1_q;
    logic         first_q;
    logic         last_q;
    logic [1:0]   mode_q;
    logic         out_valid_q;
    logic         out_last_q;

    logic [W-1:0] lane_data [LANES];

    // A single advance enable freezes both stages together under backpressure.
    assign adv     = !out_valid_q || out_ready;
    assign accept  = in_valid && adv;
    assign s2_load = adv && v1_q;
    assign mask    = q_mask(mode_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            mode_q  <= 2'd0;
        end else if (adv) begin
            v1_q <= accept;
            if (accept) begin
                first_q <= in_first;
                last_q  <= in_last;
                mode_q  <= mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v1_q;
            out_last_q  <= v1_q && last_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        frodo_mac_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .s1_load_i (accept),
            .s2_load_i (s2_load),
            .a_i       (mac_A),
            .b_i       (mac_B[W*i +: W]),
            .c_i       (mac_C[W*i +: W]),
            .first_i   (first_q),
            .mask_i    (mask),
            .data_o    (lane_data[i])
        );
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign mac_data_0 = lane_data[0];
    assign mac_data_1 = lane_data[1];
    assign mac_data_2 = lane_data[2];
    assign mac_data_3 = lane_data[3];

endmodule

// File: tb/tb_frodo_mac4.sv
// Scoreboard bench for frodo_mac4: directed scenarios plus random traffic,
// checked against an arithmetic mod-q reference model.
module tb_frodo_mac4;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic        in_last;
    logic [15:0] mac_A;
    logic [63:0] mac_B;
    logic [63:0] mac_C;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] mac_data_0;
    logic [15:0] mac_data_1;
    logic [15:0] mac_data_2;
    logic [15:0] mac_data_3;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [15:0] acc [4];
    logic [63:0] last_seen;
    logic        or_rand  = 1'b0;
    logic        or_force = 1'b1;
    logic        stall_prev = 1'b0;
    logic [64:0] stall_snap;

    frodo_mac4 dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .mac_A      (mac_A),
        .mac_B      (mac_B),
        .mac_C      (mac_C),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .mac_data_0 (mac_data_0),
        .mac_data_1 (mac_data_1),
        .mac_data_2 (mac_data_2),
        .mac_data_3 (mac_data_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] data_bus();
        return {mac_data_3, mac_data_2, mac_data_1, mac_data_0};
    endfunction

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Reference: product reduced mod 2^16, then (product + addend) mod q.
    function automatic logic [15:0] lane_res(input logic [1:0] m, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] addend);
        longint q;
        longint pr;
        q  = (m == 2'd0) ? 64'd32768 : 64'd65536;
        pr = (longint'(a) * longint'(b)) % 65536;
        return 16'((pr + longint'(addend)) % q);
    endfunction

    task automatic push_model();
        exp_t        e;
        logic [15:0] ad;
        for (int i = 0; i < 4; i++) begin
            ad     = in_first ? mac_C[16*i +: 16] : acc[i];
            acc[i] = lane_res(mode, mac_A, mac_B[16*i +: 16], ad);
            e.d[16*i +: 16] = acc[i];
        end
        e.last = in_last;
        exp_q.push_back(e);
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_force;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL in_ready: got %b, required %b", in_ready, !out_valid || out_ready);
            end
            if (stall_prev) begin
                total++;
                if (!(out_valid === 1'b1 && {out_last, data_bus()} === stall_snap)) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h",
                             out_valid, {out_last, data_bus()}, stall_snap);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_snap = {out_last, data_bus()};
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %h, required no output", data_bus());
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    last_seen = data_bus();
                    if (data_bus() !== e.d || out_last !== e.last) begin
                        bad++;
                        $display("FAIL result: got %h last=%b, required %h last=%b",
                                 data_bus(), out_last, e.d, e.last);
                    end
                end
            end
        end
    end

    // Entered and left at posedge+1; the model sees the beat when the DUT does.
    task automatic beat(input logic [1:0] m, input logic [15:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic f, input logic l);
        int n;
        n        = 0;
        mode     = m;
        mac_A    = a;
        mac_B    = b;
        mac_C    = c;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                push_model();
                break;
            end
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL beat_timeout: got in_ready=0 for %0d cycles, required accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results pending, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) acc[i] = 16'd0;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        mode = 2'd0; mac_A = '0; mac_B = '0; mac_C = '0; out_ready = 1'b1;
        #3;
        chk("reset_state", {out_valid, out_last, data_bus()}, 66'd0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        idle(2);

        // single beat with 2-cycle latency
        beat(2'd1, 16'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b1, 1'b1);
        @(negedge clk);
        chk("latency_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("latency_c2", {63'd0, out_valid}, 64'd1);
        drain();
        chk("single_beat", last_seen, {16'd52, 16'd39, 16'd26, 16'd13});

        // three-beat accumulation
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd5), 1'b1, 1'b0);
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b0);
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b1);
        drain();
        chk("accum3", last_seen, rep4(16'd11));

        // modulus wrap in each mask width
        beat(2'd0, 16'h4000, rep4(16'd2), rep4(16'h7FFF), 1'b1, 1'b1);
        drain();
        chk("wrap_mode0", last_seen, rep4(16'h7FFF));
        beat(2'd1, 16'h4000, rep4(16'd2), rep4(16'h7FFF), 1'b1, 1'b1);
        drain();
        chk("wrap_mode1", last_seen, rep4(16'hFFFF));

        // bubbles inside a sum
        beat(2'd1, 16'd0, rep4(16'd0), rep4(16'd5), 1'b1, 1'b0);
        idle(2);
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b0);
        idle(2);
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b1);
        drain();
        chk("bubble", last_seen, rep4(16'd9));

        // three-cycle output stall mid-stream
        fork
            begin
                beat(2'd2, 16'd2, rep4(16'd1), rep4(16'd5), 1'b1, 1'b0);
                beat(2'd2, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b0);
                beat(2'd2, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b0);
                beat(2'd2, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                or_force = 1'b0;
                repeat (3) @(negedge clk);
                or_force = 1'b1;
            end
        join
        drain();
        chk("backpressure", last_seen, rep4(16'd13));

        // async reset with beats in flight
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd5), 1'b1, 1'b0);
        beat(2'd1, 16'd2, rep4(16'd1), rep4(16'd0), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {out_valid, out_last, data_bus()}, 66'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) acc[i] = 16'd0;
        @(posedge clk);
        #3 rst = 1'b0;
        idle(1);
        beat(2'd1, 16'd1, rep4(16'd4), rep4(16'd0), 1'b0, 1'b1);
        drain();
        chk("after_reset", last_seen, rep4(16'd4));

        // random traffic with random backpressure
        or_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            beat(2'($urandom_range(0, 3)), 16'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        or_rand  = 1'b0;
        or_force = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
